// File: rtl/la_capture_core.sv
// Embedded logic-analyser capture engine: pre-trigger history, masked trigger
// detection (match/rising/falling/change) and rotated readback of a DEPTH-entry buffer.
module la_capture_core #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned TRIG_W = 4,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              sys_clk,
  input  logic              rst_i,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic [1:0]        trig_mode_i,
  input  logic [TRIG_W-1:0] trig_value_i,
  input  logic [TRIG_W-1:0] trig_mask_i,
  input  logic [ADDR_W-1:0] pretrig_i,
  input  logic [TRIG_W-1:0] trig_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [2:0]        state_o,
  output logic              triggered_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] trig_addr_o
);

  localparam logic [ADDR_W-1:0] LP_MAX_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [1:0] MODE_MATCH  = 2'd0;
  localparam logic [1:0] MODE_RISE   = 2'd1;
  localparam logic [1:0] MODE_FALL   = 2'd2;
  localparam logic [1:0] MODE_CHANGE = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              r_state, w_next;
  logic [1:0]          r_mode;
  logic [TRIG_W-1:0]   r_value, r_mask, r_trig_prev;
  logic [ADDR_W-1:0]   r_pretrig, r_wr_ptr, r_cnt, r_trig_addr;
  logic                r_m_prev, r_triggered, r_done;
  logic [DATA_W-1:0]   r_rd_data;
  logic [DATA_W-1:0]   r_buf [DEPTH];

  logic                w_m, w_m_arm, w_chg, w_hit, w_arm_ok, w_wr_en;
  logic [ADDR_W-1:0]   w_pretrig_clamp, w_post_len, w_rd_phys;

  // Clamp only bites when DEPTH is not a power of two.
  assign w_pretrig_clamp = ({1'b0, pretrig_i} > {1'b0, LP_MAX_IDX}) ? LP_MAX_IDX : pretrig_i;
  assign w_m        = ((trig_i ^ r_value) & r_mask) == '0;
  assign w_m_arm    = ((trig_i ^ trig_value_i) & trig_mask_i) == '0;
  assign w_chg      = |((trig_i ^ r_trig_prev) & r_mask);
  assign w_post_len = LP_MAX_IDX - r_pretrig;
  assign w_arm_ok   = arm_i && !abort_i && (r_state == S_IDLE || r_state == S_DONE);
  assign w_wr_en    = (r_state == S_PRE) || (r_state == S_WAIT) || (r_state == S_POST);
  assign w_rd_phys  = r_trig_addr - r_pretrig + rd_addr_i;

  always_comb begin
    w_hit = 1'b0;
    case (r_mode)
      MODE_MATCH:  w_hit = w_m;
      MODE_RISE:   w_hit = w_m && !r_m_prev;
      MODE_FALL:   w_hit = !w_m && r_m_prev;
      MODE_CHANGE: w_hit = w_chg;
      default:     w_hit = 1'b0;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (abort_i) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: if (arm_i) w_next = (w_pretrig_clamp != '0) ? S_PRE : S_WAIT;
        S_PRE:          if (r_cnt == r_pretrig - ADDR_W'(1)) w_next = S_WAIT;
        S_WAIT:         if (w_hit) w_next = (w_post_len == '0) ? S_DONE : S_POST;
        S_POST:         if (r_cnt == ADDR_W'(1)) w_next = S_DONE;
        default:        w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge rst_i) begin
    if (rst_i) begin
      r_mode      <= '0;
      r_value     <= '0;
      r_mask      <= '0;
      r_pretrig   <= '0;
      r_trig_prev <= '0;
      r_m_prev    <= 1'b0;
      r_wr_ptr    <= '0;
      r_cnt       <= '0;
      r_trig_addr <= '0;
      r_triggered <= 1'b0;
      r_done      <= 1'b0;
      r_rd_data   <= '0;
    end else begin
      r_trig_prev <= trig_i;
      // On arm, seed m_prev from the new compare so rising/falling see a clean history.
      r_m_prev    <= w_arm_ok ? w_m_arm : w_m;
      r_rd_data   <= r_buf[w_rd_phys];
      if (abort_i) begin
        r_triggered <= 1'b0;
        r_done      <= 1'b0;
      end else if (w_arm_ok) begin
        r_mode      <= trig_mode_i;
        r_value     <= trig_value_i;
        r_mask      <= trig_mask_i;
        r_pretrig   <= w_pretrig_clamp;
        r_wr_ptr    <= '0;
        r_cnt       <= '0;
        r_triggered <= 1'b0;
        r_done      <= 1'b0;
      end else begin
        if (w_wr_en) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
        case (r_state)
          S_PRE: r_cnt <= r_cnt + ADDR_W'(1);
          S_WAIT: begin
            if (w_hit) begin
              r_trig_addr <= r_wr_ptr;
              r_triggered <= 1'b1;
              r_cnt       <= w_post_len;
            end
          end
          S_POST:  r_cnt <= r_cnt - ADDR_W'(1);
          default: ;
        endcase
        if (r_state != S_DONE && w_next == S_DONE) r_done <= 1'b1;
      end
    end
  end

  // Buffer RAM is intentionally not reset.
  always_ff @(posedge sys_clk) begin
    if (w_wr_en) r_buf[r_wr_ptr] <= data_i;
  end

  assign rd_data_o   = r_rd_data;
  assign state_o     = r_state;
  assign triggered_o = r_triggered;
  assign done_o      = r_done;
  assign trig_addr_o = r_trig_addr;

endmodule

// File: tb/tb_la_capture_core.sv
// Directed bench for la_capture_core with DEPTH=16: trigger modes, pre-trigger
// boundaries, abort/arm interplay and asynchronous reset.
module tb_la_capture_core;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned TRIG_W = 4;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;

  logic              sys_clk, rst_i, arm_i, abort_i;
  logic [1:0]        trig_mode_i;
  logic [TRIG_W-1:0] trig_value_i, trig_mask_i, trig_i;
  logic [ADDR_W-1:0] pretrig_i, rd_addr_i, trig_addr_o;
  logic [DATA_W-1:0] data_i, rd_data_o;
  logic [2:0]        state_o;
  logic              triggered_o, done_o;

  int n_cmp = 0;
  int n_err = 0;
  bit data_run = 1'b0;
  bit trig_run = 1'b0;

  la_capture_core #(.DATA_W(DATA_W), .TRIG_W(TRIG_W), .DEPTH(DEPTH)) dut (
    .sys_clk(sys_clk), .rst_i(rst_i), .arm_i(arm_i), .abort_i(abort_i),
    .trig_mode_i(trig_mode_i), .trig_value_i(trig_value_i), .trig_mask_i(trig_mask_i),
    .pretrig_i(pretrig_i), .trig_i(trig_i), .data_i(data_i), .rd_addr_i(rd_addr_i),
    .rd_data_o(rd_data_o), .state_o(state_o), .triggered_o(triggered_o),
    .done_o(done_o), .trig_addr_o(trig_addr_o)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
    if (data_run) data_i = data_i + 8'd1;
    if (trig_run) trig_i = data_i[3:0];
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic set_cfg(input logic [1:0] mode, input logic [3:0] val,
                         input logic [3:0] msk, input logic [3:0] pre);
    trig_mode_i = mode; trig_value_i = val; trig_mask_i = msk; pretrig_i = pre;
  endtask

  task automatic arm_pulse();
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
  endtask

  // Counter capture: PRE samples 1..4, trigger on 0x0A at addr 9, window 6..21.
  task automatic scn1(input string pfx);
    set_cfg(2'd0, 4'hA, 4'hF, 4'd4);
    data_i = 8'd0; trig_i = 4'd0; data_run = 1'b1; trig_run = 1'b1;
    arm_pulse();
    chk({pfx, "_pre_entry"}, 32'(state_o), 32'd1);
    ticks(3);
    chk({pfx, "_pre_hold"}, 32'(state_o), 32'd1);
    tick();
    chk({pfx, "_wait_entry"}, 32'(state_o), 32'd2);
    ticks(5);
    chk({pfx, "_wait_hold"}, 32'(state_o), 32'd2);
    chk({pfx, "_not_trig"}, 32'(triggered_o), 32'd0);
    tick();
    chk({pfx, "_post_entry"}, 32'(state_o), 32'd3);
    chk({pfx, "_triggered"}, 32'(triggered_o), 32'd1);
    chk({pfx, "_trig_addr"}, 32'(trig_addr_o), 32'd9);
    ticks(10);
    chk({pfx, "_post_hold"}, 32'(done_o), 32'd0);
    tick();
    chk({pfx, "_done_state"}, 32'(state_o), 32'd4);
    chk({pfx, "_done"}, 32'(done_o), 32'd1);
    data_run = 1'b0; trig_run = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rd_addr_i = 4'(i);
      tick();
      chk({pfx, "_rd"}, 32'(rd_data_o), 32'(8'(6 + i)));
    end
  endtask

  initial begin
    rst_i = 1'b1; arm_i = 1'b0; abort_i = 1'b0;
    set_cfg(2'd0, 4'd0, 4'd0, 4'd0);
    trig_i = '0; data_i = '0; rd_addr_i = '0;
    ticks(2);
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_trig", 32'(triggered_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_taddr", 32'(trig_addr_o), 32'd0);
    chk("rst_rdata", 32'(rd_data_o), 32'd0);
    rst_i = 1'b0;
    tick();

    scn1("s1");

    // Rising edge on bit0, pretrig 0; arm during POST must be ignored.
    set_cfg(2'd1, 4'd1, 4'd1, 4'd0);
    trig_i = 4'd1; data_i = 8'h40; data_run = 1'b1;
    arm_pulse();
    chk("s2_wait_entry", 32'(state_o), 32'd2);
    ticks(3);
    chk("s2_held_high", 32'(triggered_o), 32'd0);
    trig_i = 4'd0;
    tick();
    chk("s2_low", 32'(triggered_o), 32'd0);
    trig_i = 4'd1;
    tick();
    chk("s2_rise_trig", 32'(triggered_o), 32'd1);
    chk("s2_rise_state", 32'(state_o), 32'd3);
    chk("s2_trig_addr", 32'(trig_addr_o), 32'd4);
    ticks(5);
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
    chk("s5_arm_in_post", 32'(state_o), 32'd3);
    ticks(8);
    chk("s3_post_14", 32'(done_o), 32'd0);
    tick();
    chk("s3_done_15", 32'(done_o), 32'd1);
    chk("s5_trig_kept", 32'(triggered_o), 32'd1);
    data_run = 1'b0;
    rd_addr_i = 4'd0;
    tick();
    chk("s3_rd0_trig", 32'(rd_data_o), 32'h45);
    rd_addr_i = 4'd15;
    tick();
    chk("s3_rd15", 32'(rd_data_o), 32'h54);

    // pretrig 15: trigger sample is the last entry, DONE straight after trigger.
    set_cfg(2'd0, 4'd5, 4'hF, 4'd15);
    trig_i = 4'd0; data_i = 8'h80; data_run = 1'b1;
    arm_pulse();
    chk("s3b_pre", 32'(state_o), 32'd1);
    ticks(14);
    chk("s3b_pre_hold", 32'(state_o), 32'd1);
    tick();
    chk("s3b_wait", 32'(state_o), 32'd2);
    trig_i = 4'd5;
    tick();
    chk("s3b_done_state", 32'(state_o), 32'd4);
    chk("s3b_done", 32'(done_o), 32'd1);
    chk("s3b_taddr", 32'(trig_addr_o), 32'd15);
    data_run = 1'b0;
    rd_addr_i = 4'd15;
    tick();
    chk("s3b_rd15_trig", 32'(rd_data_o), 32'h90);
    rd_addr_i = 4'd0;
    tick();
    chk("s3b_rd0", 32'(rd_data_o), 32'h81);

    // Change mode with mask 0x2.
    set_cfg(2'd3, 4'd0, 4'h2, 4'd0);
    trig_i = 4'd0;
    arm_pulse();
    trig_i = 4'd1;
    tick();
    trig_i = 4'd0;
    tick();
    chk("s4_bit0_ignored", 32'(triggered_o), 32'd0);
    trig_i = 4'd2;
    tick();
    chk("s4_bit1_trig", 32'(triggered_o), 32'd1);
    chk("s4_bit1_state", 32'(state_o), 32'd3);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("s4_abort_post", 32'(state_o), 32'd0);
    chk("s4_abort_clr", 32'(triggered_o), 32'd0);

    // Change mode with mask 0 never fires; then abort from WAIT.
    set_cfg(2'd3, 4'd0, 4'd0, 4'd0);
    arm_pulse();
    for (int k = 0; k < 6; k++) begin
      trig_i = ~trig_i;
      tick();
    end
    chk("s4_mask0_wait", 32'(state_o), 32'd2);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("s5_abort_wait", 32'(state_o), 32'd0);
    chk("s5_abort_done", 32'(done_o), 32'd0);

    // Match mode with mask 0 fires on the first WAIT cycle.
    set_cfg(2'd0, 4'hF, 4'd0, 4'd0);
    trig_i = 4'd3;
    arm_pulse();
    chk("m0_wait", 32'(state_o), 32'd2);
    tick();
    chk("m0_trig", 32'(triggered_o), 32'd1);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;

    // Arm and abort together in IDLE: abort wins.
    arm_i = 1'b1; abort_i = 1'b1;
    tick();
    arm_i = 1'b0; abort_i = 1'b0;
    chk("s5_arm_abort", 32'(state_o), 32'd0);

    // Asynchronous reset in the middle of POST.
    set_cfg(2'd0, 4'hA, 4'hF, 4'd4);
    data_i = 8'd0; trig_i = 4'd0; data_run = 1'b1; trig_run = 1'b1;
    arm_pulse();
    ticks(13);
    chk("s6_in_post", 32'(state_o), 32'd3);
    #3;
    rst_i = 1'b1;
    #1;
    chk("s6_async_state", 32'(state_o), 32'd0);
    chk("s6_async_trig", 32'(triggered_o), 32'd0);
    chk("s6_async_done", 32'(done_o), 32'd0);
    chk("s6_async_taddr", 32'(trig_addr_o), 32'd0);
    chk("s6_async_rdata", 32'(rd_data_o), 32'd0);
    #1;
    rst_i = 1'b0;
    data_run = 1'b0; trig_run = 1'b0;
    scn1("s6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/la_capture_core.md
Name: la_capture_core

Overview:
- Parametrised embedded logic-analyser capture engine for on-chip debug of the audio path, e.g. the EQ gain-write/gain-set/reset strobes.
- Generalises a fixed two-bit trigger and three-bit capture analyser with configurable trigger and data widths, buffer depth, and a programmable pre-trigger depth.
- Supports four trigger modes (match, rising, falling, any-change) and masked trigger compare.
- Sits between probed design signals and a readback/control host, such as a JTAG bridge or UART register block, all in the sys_clk domain.

Parameters:
DATA_W, 8, captured sample width in bits.
TRIG_W, 4, trigger bus width in bits.
DEPTH, 256, number of sample buffer entries; must be a power of two and at least 4.
ADDR_W, $clog2(DEPTH), buffer address width; derived, not overridden.

Ports:
sys_clk  in  1  capture clock; all logic is rising-edge.
rst_i  in  1  asynchronous, active-high reset.
arm_i  in  1  single-cycle pulse; starts a capture.
abort_i  in  1  single-cycle pulse; cancels the capture.
trig_mode_i  in  2  trigger mode: 00 match, 01 rising, 10 falling, 11 change.
trig_value_i  in  TRIG_W  trigger compare value.
trig_mask_i  in  TRIG_W  trigger compare mask; 1 means the bit participates.
pretrig_i  in  ADDR_W  number of samples kept before the trigger sample.
trig_i  in  TRIG_W  probed trigger signals.
data_i  in  DATA_W  probed data signals.
rd_addr_i  in  ADDR_W  logical read index; 0 is the oldest sample.
rd_data_o  out  DATA_W  read data, registered.
state_o  out  3  current state: 0 IDLE, 1 PRE, 2 WAIT, 3 POST, 4 DONE.
triggered_o  out  1  trigger has occurred in the current capture.
done_o  out  1  buffer is full and valid.
trig_addr_o  out  ADDR_W  physical buffer address of the trigger sample.

Behaviour:
- Reset (asynchronous): state IDLE; all outputs 0; pointers, counters and previous-trigger register 0. Buffer RAM contents are not reset.
- Configuration latching: trig_mode_i, trig_value_i, trig_mask_i and pretrig_i are latched on an accepted arm. Changing them mid-capture has no effect.
- pretrig clamp: a latched pretrig_i greater than DEPTH-1 is clamped to DEPTH-1. This clamp only matters for non-power-of-two use; keep the check in the RTL.
- Arm acceptance: arm_i is accepted only in IDLE or DONE. An accepted arm clears wr_ptr, the sample counter, triggered_o and done_o, then:
  - next state is PRE if pretrig > 0;
  - otherwise next state is WAIT.
- Arm is ignored in PRE, WAIT and POST.
- Abort: abort_i in any state forces IDLE on the next edge and clears done_o and triggered_o. If arm_i and abort_i arrive in the same cycle, abort wins.
- Sample writes: in PRE, WAIT and POST, data_i is written to buf[wr_ptr] every cycle and wr_ptr increments modulo DEPTH (wraps at DEPTH-1 to 0).
- PRE: counts written samples. After pretrig samples it moves to WAIT. Trigger conditions are ignored in PRE.
- Trigger conditions (let m = (trig_i & mask) == (value & mask)):
  - match: m.
  - rising: m && !m_prev.
  - falling: !m && m_prev.
  - change: ((trig_i ^ trig_prev) & mask) != 0.
- Previous-trigger tracking: trig_prev and m_prev are registered every cycle in every state.
- Degenerate mask: mask = 0 in match mode triggers on the first WAIT cycle. In change mode it never triggers.
- WAIT: samples wrap freely. On the cycle the condition is true, that cycle's sample is the trigger sample:
  - trig_addr_o <= wr_ptr and triggered_o <= 1;
  - post counter loads DEPTH-1-pretrig;
  - next state is POST, or DONE if the post count is 0.
- POST: writes the remaining post-trigger samples. After the last write it moves to DONE and sets done_o = 1.
- Buffer contents at DONE: exactly DEPTH samples, namely pretrig samples before the trigger sample, the trigger sample, then DEPTH-1-pretrig samples after it.
- Readback address: start = trig_addr - pretrig (mod DEPTH). The physical read address is start + rd_addr_i (mod DEPTH).
- Readback timing: rd_data_o is updated 1 cycle after rd_addr_i. It is valid only while done_o = 1 and is undefined otherwise.
- DONE: holds until arm_i or abort_i. The buffer is not written in DONE or IDLE.
- Single-port buffer RAM is sufficient: writes and reads never overlap in the valid state.

Test Plan:
1. DEPTH=16, pretrig=4, match, value=0xA, mask=0xF; data_i is a free-running counter and trig_i = data_i[3:0]; arm -> state goes 1 then 2 then 3 then 4. Reads 0..15 return V-4..V+11, where V is the first counter value with V[3:0]=0xA after 4 PRE samples; read 4 returns V.
2. Rising mode, value=1, mask=1, trig_i[0] held at 1 before and after arm -> no trigger. trig_i[0] goes 0 and then 1 -> trigger on the 1 sample; triggered_o rises the next cycle.
3. pretrig=0 -> read 0 is the trigger sample and done_o follows 15 cycles later. pretrig=15 -> read 15 is the trigger sample, with DONE the cycle after the trigger.
4. Change mode, mask=0x2, toggle only trig_i[0] -> no trigger. Toggle trig_i[1] -> trigger. Mask=0 in change mode -> stays in WAIT forever.
5. abort_i during WAIT -> state 0 next cycle with done_o=0. arm_i and abort_i together in IDLE -> stays IDLE. arm_i during POST -> ignored and capture completes normally.
6. rst_i asserted asynchronously mid-POST -> all outputs 0 immediately without waiting for a clock. A re-arm after reset captures correctly per scenario 1.
